// File: rtl/gsensor_spi_responder.sv
// gsensor_spi_responder: SPI mode-3 slave that models the accelerometer end of the
// gsensor_* link. It holds a 64x8 register file, and a local port can read and write it.
//
// Ports:
//   clk_clk, reset_reset      system clock and synchronous active-high reset
//   gsensor_SCLK/MOSI/SS_n    SPI inputs from the master (SCLK idles high)
//   gsensor_MISO, _oe         SPI data back to the master, plus its drive enable
//   reg_wr_en/addr/wdata      local write port
//   reg_rdata                 local read data (registered, 1-cycle latency)
//   spi_wr_strobe/addr/data   one-cycle pulse with address and data for each SPI byte write
//   frame_err                 one-cycle pulse when SS_n rises partway through a byte
//
// Build option: define GSENSOR_RESP_DEVID_LOCK_EN to make register 0x00 a read-only
// DEVID_VAL. Without it, 0x00 is an ordinary register.
module gsensor_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_VAL   = 8'hE5,
    parameter int         ADDR_W      = 6
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              gsensor_SCLK,
    input  logic              gsensor_MOSI,
    input  logic              gsensor_SS_n,
    output logic              gsensor_MISO,
    output logic              gsensor_MISO_oe,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [7:0]        reg_wdata,
    output logic [7:0]        reg_rdata,
    output logic              spi_wr_strobe,
    output logic [ADDR_W-1:0] spi_wr_addr,
    output logic [7:0]        spi_wr_data,
    output logic              frame_err
);

`ifdef GSENSOR_RESP_DEVID_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WR,
        S_RD
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic [SYNC_STAGES-1:0] ss_sr;
    logic                   sclk_prev;
    logic                   ss_prev;

    logic sclk_s;
    logic mosi_s;
    logic ss_s;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_rise;
    logic ss_fall;

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_shift;
    logic [7:0]        tx_shift;
    logic [7:0]        rx_byte;
    logic              cmd_mb;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        mem [DEPTH];

    function automatic logic is_locked(input logic [ADDR_W-1:0] a);
        return LOCK_EN && (a == '0);
    endfunction

    function automatic logic [7:0] rd_reg(input logic [ADDR_W-1:0] a);
        return is_locked(a) ? DEVID_VAL : mem[a];
    endfunction

    assign sclk_s = sclk_sr[SYNC_STAGES-1];
    assign mosi_s = mosi_sr[SYNC_STAGES-1];
    assign ss_s   = ss_sr[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_rise   = ss_s & ~ss_prev;
    assign ss_fall   = ~ss_s & ss_prev;

    // The received byte includes the bit sampled on this rise.
    assign rx_byte   = {rx_shift[6:0], mosi_s};
    assign next_addr = cmd_mb ? addr + ADDR_W'(1) : addr;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sclk_sr         <= '1;
            mosi_sr         <= '0;
            // SS_n is treated as "low" out of reset. If it really is low (a frame
            // was already running), no falling edge is ever seen and the rest of
            // that frame is ignored until SS_n goes high.
            ss_sr           <= '0;
            sclk_prev       <= 1'b1;
            ss_prev         <= 1'b0;
            state           <= S_IDLE;
            bit_cnt         <= 3'd0;
            rx_shift        <= 8'h00;
            tx_shift        <= 8'hFF;
            cmd_mb          <= 1'b0;
            addr            <= '0;
            gsensor_MISO    <= 1'b1;
            gsensor_MISO_oe <= 1'b0;
            reg_rdata       <= 8'h00;
            spi_wr_strobe   <= 1'b0;
            spi_wr_addr     <= '0;
            spi_wr_data     <= 8'h00;
            frame_err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], gsensor_SCLK};
            mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], gsensor_MOSI};
            ss_sr     <= {ss_sr[SYNC_STAGES-2:0], gsensor_SS_n};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;

            spi_wr_strobe <= 1'b0;
            frame_err     <= 1'b0;
            reg_rdata     <= rd_reg(reg_addr);

            // The local write is assigned first, so an SPI write to the same
            // address in the same cycle overrides it.
            if (reg_wr_en && !is_locked(reg_addr)) begin
                mem[reg_addr] <= reg_wdata;
            end

            if (ss_rise) begin
                state           <= S_IDLE;
                gsensor_MISO_oe <= 1'b0;
                gsensor_MISO    <= 1'b1;
                bit_cnt         <= 3'd0;
                frame_err       <= (bit_cnt != 3'd0);
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (ss_fall) begin
                            state   <= S_CMD;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_CMD: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_byte;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                cmd_mb <= rx_byte[6];
                                addr   <= rx_byte[ADDR_W-1:0];
                                if (rx_byte[7]) begin
                                    state           <= S_RD;
                                    tx_shift        <= rd_reg(rx_byte[ADDR_W-1:0]);
                                    gsensor_MISO_oe <= 1'b1;
                                end else begin
                                    state <= S_WR;
                                end
                            end
                        end
                    end
                    S_WR: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_byte;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (!is_locked(addr)) begin
                                    mem[addr]     <= rx_byte;
                                    spi_wr_strobe <= 1'b1;
                                    spi_wr_addr   <= addr;
                                    spi_wr_data   <= rx_byte;
                                end
                                addr <= next_addr;
                            end
                        end
                    end
                    S_RD: begin
                        if (sclk_fall) begin
                            gsensor_MISO <= tx_shift[7];
                            tx_shift     <= {tx_shift[6:0], 1'b1};
                        end else if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                addr     <= next_addr;
                                tx_shift <= rd_reg(next_addr);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// tb_gsensor_spi_responder: directed and random SPI frames against a byte-level
// register model, with strobe and frame-error monitoring.
`timescale 1ns/1ps
module tb_gsensor_spi_responder;

    localparam int HALF = 8;
    localparam int SYNC = 2;
`ifdef GSENSOR_RESP_DEVID_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       mosi;
    logic       ss_n;
    logic       miso;
    logic       miso_oe;
    logic       wr_en;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       strobe;
    logic [5:0] s_addr;
    logic [7:0] s_data;
    logic       ferr;

    always #5 clk = ~clk;

    gsensor_spi_responder #(.SYNC_STAGES(SYNC)) dut (
        .clk_clk         (clk),
        .reset_reset     (rst),
        .gsensor_SCLK    (sclk),
        .gsensor_MOSI    (mosi),
        .gsensor_SS_n    (ss_n),
        .gsensor_MISO    (miso),
        .gsensor_MISO_oe (miso_oe),
        .reg_wr_en       (wr_en),
        .reg_addr        (addr),
        .reg_wdata       (wdata),
        .reg_rdata       (rdata),
        .spi_wr_strobe   (strobe),
        .spi_wr_addr     (s_addr),
        .spi_wr_data     (s_data),
        .frame_err       (ferr)
    );

    int tests = 0;
    int fails = 0;
    int fe_cnt = 0;
    int obs_rd = 0;
    logic [13:0] obs_q[$];
    logic [13:0] exp_q[$];
    logic [7:0]  mm [64];
    logic [7:0]  tx_buf [4];
    logic [7:0]  rx_buf [4];
    logic        oe_all;
    logic        oe_any;
    logic [5:0]  coll_addr;
    logic [7:0]  coll_data;

    always @(negedge clk) begin
        if (strobe) obs_q.push_back({s_addr, s_data});
        if (ferr) fe_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_rd(input int a);
        return (LOCK && a == 0) ? 8'hE5 : mm[a];
    endfunction

    task automatic m_wr(input int a, input logic [7:0] d);
        if (!(LOCK && a == 0)) begin
            mm[a] = d;
            exp_q.push_back({6'(a), d});
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 64; i++) mm[i] = 8'h00;
    endtask

    task automatic check_strobes(input string tag);
        chk({tag, "_nstrobe"}, 16'(obs_q.size() - obs_rd), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && obs_rd + i < obs_q.size(); i++)
            chk({tag, "_strobe"}, 16'(obs_q[obs_rd + i]), 16'(exp_q[i]));
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    task automatic local_write(input int a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = 6'(a);
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (!(LOCK && a == 0)) mm[a] = d;
    endtask

    task automatic local_read(input int a, output logic [7:0] d);
        @(negedge clk);
        addr = 6'(a);
        @(negedge clk);
        d = rdata;
    endtask

    // Call at a negedge. One SCLK period: fall, then the master samples and raises SCLK.
    task automatic spi_bit(input logic b, input logic coll, output logic r, output logic oe);
        sclk = 1'b0;
        mosi = b;
        repeat (HALF) @(negedge clk);
        r    = miso;
        oe   = miso_oe;
        sclk = 1'b1;
        if (coll) begin
            repeat (SYNC) @(negedge clk);
            wr_en = 1'b1;
            addr  = coll_addr;
            wdata = coll_data;
            @(negedge clk);
            wr_en = 1'b0;
            repeat (HALF - SYNC - 1) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic frame(input logic [7:0] cmd, input int nbytes, input int tail,
                         input logic coll);
        logic r;
        logic oe;
        logic [7:0] acc;
        oe_all = 1'b1;
        oe_any = 1'b0;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 7; b >= 0; b--) spi_bit(cmd[b], 1'b0, r, oe);
        for (int i = 0; i < nbytes; i++) begin
            acc = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                spi_bit(tx_buf[i][b], coll && (i == nbytes - 1) && (b == 0), r, oe);
                acc    = {acc[6:0], r};
                oe_all = oe_all & oe;
                oe_any = oe_any | oe;
            end
            rx_buf[i] = acc;
        end
        for (int t = 0; t < tail; t++) spi_bit(tx_buf[nbytes][7-t], 1'b0, r, oe);
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic txn(input string tag, input logic [7:0] cmd, input int nbytes);
        int a;
        a = int'(cmd[5:0]);
        frame(cmd, nbytes, 0, 1'b0);
        for (int i = 0; i < nbytes; i++) begin
            if (cmd[7]) chk({tag, "_rd"}, 16'(rx_buf[i]), 16'(m_rd(a)));
            else m_wr(a, tx_buf[i]);
            if (cmd[6]) a = (a + 1) % 64;
        end
        if (cmd[7]) chk({tag, "_oe_rd"}, 16'(oe_all), 16'(1));
        else chk({tag, "_oe_wr"}, 16'(oe_any), 16'(0));
        check_strobes(tag);
        chk({tag, "_idle_pins"}, 16'({miso_oe, miso}), 16'(2'b01));
    endtask

    initial begin
        logic [7:0] d;
        logic r;
        logic oe;
        logic [7:0] cmd;
        int fe0;
        int nb;

        rst   = 1'b1;
        sclk  = 1'b1;
        mosi  = 1'b0;
        ss_n  = 1'b1;
        wr_en = 1'b0;
        addr  = 6'd0;
        wdata = 8'h00;
        coll_addr = 6'd0;
        coll_data = 8'h00;
        m_clear();
        repeat (4) @(negedge clk);
        chk("rst_miso", 16'(miso), 16'(1));
        chk("rst_oe", 16'(miso_oe), 16'(0));
        chk("rst_rdata", 16'(rdata), 16'(0));
        chk("rst_strobe", 16'(strobe), 16'(0));
        chk("rst_ferr", 16'(ferr), 16'(0));
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_pins", 16'({miso_oe, miso}), 16'(2'b01));

        // 1: local write, SPI single-byte read
        local_write(6'h32, 8'hA5);
        txn("t1", 8'hB2, 1);
        chk("t1_val", 16'(rx_buf[0]), 16'(8'hA5));

        // 2: multi-byte SPI write, local readback
        tx_buf[0] = 8'h11;
        tx_buf[1] = 8'h22;
        txn("t2", 8'h72, 2);
        local_read(6'h32, d);
        chk("t2_rd32", 16'(d), 16'(8'h11));
        local_read(6'h33, d);
        chk("t2_rd33", 16'(d), 16'(8'h22));

        // 3: multi-byte read wrapping 63 -> 0
        local_write(63, 8'h3C);
        local_write(0, 8'h5A);
        txn("t3", 8'hFF, 2);
        chk("t3_b0", 16'(rx_buf[0]), 16'(8'h3C));
        chk("t3_b1", 16'(rx_buf[1]), 16'(LOCK ? 8'hE5 : 8'h5A));

        // 4: SS_n raised after 4 data bits
        local_write(5, 8'h99);
        tx_buf[0] = 8'hF0;
        fe0 = fe_cnt;
        frame(8'h05, 0, 4, 1'b0);
        chk("t4_ferr", 16'(fe_cnt - fe0), 16'(1));
        check_strobes("t4");
        local_read(5, d);
        chk("t4_reg5", 16'(d), 16'(8'h99));
        txn("t4_after", 8'h85, 1);

        // 5: local and SPI write to 0x10 in the same cycle
        coll_addr = 6'h10;
        coll_data = 8'h00;
        tx_buf[0] = 8'h7E;
        frame(8'h10, 1, 0, 1'b1);
        m_wr(6'h10, 8'h7E);
        check_strobes("t5");
        local_read(6'h10, d);
        chk("t5_reg10", 16'(d), 16'(8'h7E));

        // 6: SPI write then read of register 0x00
        tx_buf[0] = 8'h55;
        txn("t6_wr", 8'h00, 1);
        txn("t6_rd", 8'h80, 1);
        chk("t6_val", 16'(rx_buf[0]), 16'(LOCK ? 8'hE5 : 8'h55));

        // SCLK toggling with SS_n high is ignored
        fe0 = fe_cnt;
        for (int k = 0; k < 4; k++) begin
            sclk = 1'b0;
            mosi = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        check_strobes("ss_high");
        chk("ss_high_ferr", 16'(fe_cnt - fe0), 16'(0));
        chk("ss_high_pins", 16'({miso_oe, miso}), 16'(2'b01));

        // Reset in the middle of a write frame: the rest of the frame is ignored
        local_write(5, 8'h66);
        fe0 = fe_cnt;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 7; b >= 4; b--) spi_bit(1'b0, 1'b0, r, oe);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_clear();
        chk("midrst_pins", 16'({miso_oe, miso}), 16'(2'b01));
        cmd = 8'h05;
        for (int b = 3; b >= 0; b--) spi_bit(cmd[b], 1'b0, r, oe);
        cmd = 8'hC3;
        for (int b = 7; b >= 0; b--) spi_bit(cmd[b], 1'b0, r, oe);
        repeat (HALF) @(negedge clk);
        ss_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check_strobes("midrst");
        chk("midrst_ferr", 16'(fe_cnt - fe0), 16'(0));
        local_read(5, d);
        chk("midrst_reg5", 16'(d), 16'(8'h00));
        txn("midrst_after", 8'h85, 1);

        // Random traffic against the model
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0)
                local_write(int'($urandom_range(0, 63)), 8'($urandom));
            cmd = 8'($urandom);
            nb  = int'($urandom_range(1, 3));
            for (int i = 0; i < 4; i++) tx_buf[i] = 8'($urandom);
            txn("rand", cmd, nb);
        end

        for (int a = 0; a < 64; a++) begin
            local_read(a, d);
            chk("sweep", 16'(d), 16'(m_rd(a)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
